// File: rtl/drain_pkg.sv
// drain_pkg: shared FSM state type and default geometry for the ofmap drain path
package drain_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} drain_state_t;
  localparam int DEPTH_DEF = 16;
  localparam int FRAME_LEN_DEF = 9;
  localparam int ROW_LEN_DEF = 3;
endpackage

// File: rtl/ofmap_drain_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy, full and empty flags
// Ports: clk_i/rst_i clock and sync reset; push_i/din_i write side; pop_i read request;
// dout_o head entry (zero when empty); count_o/full_o/empty_o occupancy; wr_ok_o push accepted.
module sync_fifo
  import drain_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     wr_ok_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok;
  assign empty_o = count_o == '0;
  assign full_o = count_o == (AW+1)'(DEPTH);
  assign pop_ok = pop_i && !empty_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_ok_o = push_i && (!full_o || pop_ok);
  assign dout_o = empty_o ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (wr_ok_o) mem[wr_ptr] <= din_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
    end else begin
      if (wr_ok_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + (AW+1)'(wr_ok_o) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/ofmap_drain.sv
// ofmap_drain: captures one ofmap frame from the PE array (optional ReLU) into a FWFT FIFO for the host
// Ports: clk_i/rst_i clock and sync reset; frame_start_i arms a frame; sample_i/sample_valid_i array data;
// relu_en_i clamp negatives on capture; rd_ready_i/rd_valid_o/rd_data_o/rd_last_o host read side;
// frame_done_o drained pulse; count_o/full_o/empty_o FIFO occupancy; drop_cnt_o overflow drops this frame.
module ofmap_drain
  import drain_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ROW_LEN = ROW_LEN_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frame_start_i,
  input  logic [7:0]               sample_i,
  input  logic                     sample_valid_i,
  input  logic                     relu_en_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [7:0]               rd_data_o,
  output logic                     rd_last_o,
  output logic                     frame_done_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [7:0]               drop_cnt_o
);
  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int RW = $clog2(ROW_LEN + 1);
  drain_state_t state;
  logic [FW-1:0] n_cnt;
  logic [RW-1:0] col;
  logic [7:0] cap;
  logic push, pop, wr_ok, last;
  assign push = state == COLLECT && sample_valid_i;
  assign rd_valid_o = !empty_o;
  assign pop = rd_valid_o && rd_ready_i;
  assign cap = relu_en_i && sample_i[7] ? 8'h00 : sample_i;
  assign last = col == RW'(ROW_LEN - 1);
  sync_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({last, cap}),
    .dout_o ({rd_last_o, rd_data_o}),
    .count_o(count_o),
    .full_o (full_o),
    .empty_o(empty_o),
    .wr_ok_o(wr_ok)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      n_cnt <= '0;
      col <= '0;
      drop_cnt_o <= '0;
      frame_done_o <= 1'b0;
    end else begin
      // registered so the pulse coincides exactly with the DONE state
      frame_done_o <= state == FLUSH && empty_o;
      case (state)
        IDLE: if (frame_start_i) begin
          state <= COLLECT;
          n_cnt <= '0;
          col <= '0;
          drop_cnt_o <= '0;
        end
        COLLECT: if (push) begin
          n_cnt <= n_cnt + 1'b1;
          col <= last ? '0 : col + 1'b1;
          if (!wr_ok && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 1'b1;
          if (n_cnt == FW'(FRAME_LEN - 1)) state <= FLUSH;
        end
        FLUSH: if (empty_o) state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
